// File: rtl/keynsham_uart_pkg.sv
// rtl/keynsham_uart_pkg.sv - shared state encoding and UART register offsets
package keynsham_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic [3:0] UART_DATA_OFS   = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;

endpackage

// File: rtl/keynsham_rr_pick.sv
// rtl/keynsham_rr_pick.sv - combinational round-robin picker
// Returns the first masked request at or above ptr_i, wrapping at N-1 -> 0.
module keynsham_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          found_o
);

  localparam logic [IW:0] NUM = (IW+1)'(N);

  logic [N-1:0] req_m;
  logic [IW:0]  pos;

  assign req_m = req_i & mask_i;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    pos      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = {1'b0, ptr_i} + (IW+1)'(off);
      if (pos >= NUM) pos = pos - NUM;
      for (int j = 0; j < N; j++) begin
        if (pos == (IW+1)'(j) && req_m[j]) begin
          found_o  = 1'b1;
          winner_o = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/keynsham_uart_tx_arb.sv
// rtl/keynsham_uart_tx_arb.sv - round-robin byte arbiter in front of the UART transmitter
// Packet lock enabled by defining KEYNSHAM_UART_ARB_LOCK_EN.
module keynsham_uart_tx_arb #(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_wr_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [REQ_W-1:0]     grant_id,
  output logic                 busy
);
  import keynsham_uart_pkg::*;

  arb_state_e         state_q, state_d;
  logic [REQ_W-1:0]   ptr_q, ptr_d;
  logic [REQ_W-1:0]   grant_q, grant_d;
  logic [7:0]         din_q, din_d;
  logic               wr_en_q, wr_en_d;
  logic [REQ_W-1:0]   winner;
  logic               found;
  logic               accept;
  logic [7:0]         sel_byte;
  logic               sel_last;
  logic [NUM_REQ-1:0] mask;

`ifdef KEYNSHAM_UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // While locked only the most recently granted requester may win.
  always_comb begin
    mask = '1;
    if (lock_q) begin
      for (int i = 0; i < NUM_REQ; i++) mask[i] = (grant_q == REQ_W'(i));
    end
  end
`else
  logic unused_last;

  assign mask        = '1;
  assign unused_last = sel_last;
`endif

  keynsham_rr_pick #(
    .N  (NUM_REQ),
    .IW (REQ_W)
  ) u_pick (
    .req_i    (req_valid),
    .mask_i   (mask),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // rst_n gates ready so no handshake is offered while reset is held.
  assign accept = (state_q == IDLE) && rst_n && !uart_tx_busy && found;

  always_comb begin
    sel_byte  = '0;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == REQ_W'(i)) begin
        sel_byte     = req_data[8*i +: 8];
        sel_last     = req_last[i];
        req_ready[i] = accept;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    din_d   = din_q;
    wr_en_d = wr_en_q;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          din_d   = sel_byte;
          grant_d = winner;
          ptr_d   = (winner == REQ_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          wr_en_d = 1'b1;
          state_d = ISSUE;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
          lock_d  = !sel_last;
`endif
        end
      end
      ISSUE: begin
        if (uart_tx_busy) begin
          wr_en_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!uart_tx_busy) state_d = IDLE;
      end
      default: begin
        wr_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  assign uart_wr_en = wr_en_q;
  assign uart_din   = din_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_keynsham_uart_tx_arb.sv
// tb/tb_keynsham_uart_tx_arb.sv - scoreboard bench for the UART transmit arbiter
module tb_keynsham_uart_tx_arb;

  localparam int NUM_REQ = 2;
  localparam int REQ_W   = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_wr_en;
  logic [7:0]           uart_din;
  logic                 uart_tx_busy;
  logic [REQ_W-1:0]     grant_id;
  logic                 busy;

  logic model_busy = 1'b0;
  logic force_busy;
  logic wr_prev    = 1'b0;
  int   dly        = 0;
  int   hold       = 0;
  int   wr_rises   = 0;

  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int          obs_rd;
  int          n_pass;
  int          n_total;

  keynsham_uart_tx_arb #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_wr_en   (uart_wr_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign uart_tx_busy = model_busy | force_busy;

  // UART core model: logs each write, raises busy 2 cycles later for 20 cycles.
  always @(negedge clk) begin
    if (uart_wr_en && !wr_prev) begin
      obs_q.push_back({grant_id, uart_din});
      wr_rises = wr_rises + 1;
      dly = 2;
    end
    wr_prev = uart_wr_en;
    if (dly > 0) begin
      dly = dly - 1;
      if (dly == 0) begin
        model_busy = 1'b1;
        hold = 20;
      end
    end else if (hold > 0) begin
      hold = hold - 1;
      if (hold == 0) model_busy = 1'b0;
    end
  end

  task automatic present();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    if (src0.size() != 0) begin
      req_valid[0]   = 1'b1;
      req_data[7:0]  = src0[0][7:0];
      req_last[0]    = src0[0][8];
    end
    if (src1.size() != 0) begin
      req_valid[1]   = 1'b1;
      req_data[15:8] = src1[0][7:0];
      req_last[1]    = src1[0][8];
    end
  endtask

  task automatic sample_hs();
    if (req_valid[0] && req_ready[0]) void'(src0.pop_front());
    if (req_valid[1] && req_ready[1]) void'(src1.pop_front());
  endtask

  task automatic step();
    @(negedge clk); #1;
    sample_hs();
    @(posedge clk); #1;
    present();
  endtask

  task automatic run(input string name, input int max);
    bit done = 1'b0;
    for (int c = 0; c < max; c++) begin
      step();
      if (src0.size() == 0 && src1.size() == 0 && busy === 1'b0 && uart_tx_busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    n_total++;
    if (done !== 1'b1) $display("FAIL %s_timeout: got busy=%b expected drained", name, busy);
    else n_pass++;
  endtask

  task automatic do_reset();
    src0.delete();
    src1.delete();
    present();
    force_busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    req_data  = 16'h6141;
    @(negedge clk); #1;
    n_total++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", req_ready); else n_pass++;
    n_total++; if (uart_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", uart_wr_en); else n_pass++;
    n_total++; if (uart_din !== 8'h00) $display("FAIL rst_din: got %h expected 00", uart_din); else n_pass++;
    n_total++; if (grant_id !== 3'd0) $display("FAIL rst_grant: got %0d expected 0", grant_id); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    int k;
    logic [10:0] e, o;
    do_reset();
    src0.push_back({1'b1, 8'h41});
    exp_q.push_back({3'd0, 8'h41});
    present();
    @(negedge clk); #1;
    n_total++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b expected 01", req_ready); else n_pass++;
    sample_hs();
    @(posedge clk); #1;
    present();
    @(negedge clk); #1;
    n_total++; if (req_ready !== 2'b00) $display("FAIL single_ready_pulse: got %b expected 00", req_ready); else n_pass++;
    n_total++; if (uart_wr_en !== 1'b1) $display("FAIL single_wr_lat: got %b expected 1", uart_wr_en); else n_pass++;
    n_total++; if (uart_din !== 8'h41) $display("FAIL single_din: got %h expected 41", uart_din); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
    k = 0;
    while (uart_tx_busy !== 1'b1 && k < 10) begin @(negedge clk); #1; k++; end
    n_total++; if (uart_wr_en !== 1'b1) $display("FAIL single_wr_hold: got %b expected 1", uart_wr_en); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (uart_wr_en !== 1'b0) $display("FAIL single_wr_drop: got %b expected 0", uart_wr_en); else n_pass++;
    n_total++; if (uart_din !== 8'h41) $display("FAIL single_din_stable: got %h expected 41", uart_din); else n_pass++;
    k = 0;
    while (uart_tx_busy !== 1'b0 && k < 40) begin @(negedge clk); #1; k++; end
    @(negedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy); else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_rd >= obs_q.size()) $display("FAIL single_sb: got none expected %h", e);
      else begin o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL single_sb: got %h expected %h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_contention();
    logic [10:0] e, o;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src0.push_back({1'b1, 8'h30 + 8'(i)});
      src1.push_back({1'b1, 8'h61 + 8'(i)});
      exp_q.push_back({3'd0, 8'h30 + 8'(i)});
      exp_q.push_back({3'd1, 8'h61 + 8'(i)});
    end
    present();
    run("contention", 400);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_rd >= obs_q.size()) $display("FAIL contention_sb: got none expected %h", e);
      else begin o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL contention_sb: got %h expected %h", o, e); else n_pass++; end
    end
    n_total++;
    if (obs_rd != obs_q.size()) $display("FAIL contention_extra: got %0d writes expected 6", obs_q.size() - obs_rd + 6);
    else n_pass++;
  endtask

  task automatic test_busy_idle();
    int hi;
    logic [10:0] e, o;
    do_reset();
    force_busy = 1'b1;
    src0.push_back({1'b1, 8'h5a});
    exp_q.push_back({3'd0, 8'h5a});
    present();
    hi = 0;
    repeat (8) begin @(negedge clk); #1; if (req_ready !== 2'b00) hi++; end
    n_total++; if (hi !== 0) $display("FAIL busy_idle_stall: got %0d ready cycles expected 0", hi); else n_pass++;
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk); #1;
    n_total++; if (req_ready !== 2'b01) $display("FAIL busy_idle_accept: got %b expected 01", req_ready); else n_pass++;
    sample_hs();
    @(posedge clk); #1;
    present();
    run("busy_idle", 100);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_rd >= obs_q.size()) $display("FAIL busy_idle_sb: got none expected %h", e);
      else begin o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL busy_idle_sb: got %h expected %h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_reset_drain();
    int k;
    logic [10:0] e, o;
    do_reset();
    src0.push_back({1'b1, 8'hc3});
    present();
    k = 0;
    while (!(busy === 1'b1 && uart_wr_en === 1'b0 && uart_tx_busy === 1'b1) && k < 20) begin step(); k++; end
    n_total++; if (k >= 20) $display("FAIL rdrain_reach: got %0d cycles expected DRAIN", k); else n_pass++;
    src0.push_back({1'b1, 8'ha0});
    src1.push_back({1'b1, 8'hb0});
    present();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (uart_wr_en !== 1'b0) $display("FAIL rdrain_wr_en: got %b expected 0", uart_wr_en); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rdrain_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (req_ready !== 2'b00) $display("FAIL rdrain_ready: got %b expected 00", req_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_rd = obs_q.size();
    exp_q.push_back({3'd0, 8'ha0});
    exp_q.push_back({3'd1, 8'hb0});
    run("rdrain", 200);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_rd >= obs_q.size()) $display("FAIL rdrain_sb: got none expected %h", e);
      else begin o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL rdrain_sb: got %h expected %h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_lock();
    logic [10:0] e, o;
    do_reset();
    src0.push_back({1'b0, 8'h10});
    src0.push_back({1'b0, 8'h11});
    src0.push_back({1'b1, 8'h12});
    src1.push_back({1'b1, 8'h70});
    src1.push_back({1'b1, 8'h71});
`ifdef KEYNSHAM_UART_ARB_LOCK_EN
    exp_q.push_back({3'd0, 8'h10});
    exp_q.push_back({3'd0, 8'h11});
    exp_q.push_back({3'd0, 8'h12});
    exp_q.push_back({3'd1, 8'h70});
    exp_q.push_back({3'd1, 8'h71});
`else
    exp_q.push_back({3'd0, 8'h10});
    exp_q.push_back({3'd1, 8'h70});
    exp_q.push_back({3'd0, 8'h11});
    exp_q.push_back({3'd1, 8'h71});
    exp_q.push_back({3'd0, 8'h12});
`endif
    present();
    run("lock", 400);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_rd >= obs_q.size()) $display("FAIL lock_sb: got none expected %h", e);
      else begin o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL lock_sb: got %h expected %h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_withdraw();
    int k;
    int rises0;
    logic [10:0] e, o;
    do_reset();
    src0.push_back({1'b1, 8'h22});
    exp_q.push_back({3'd0, 8'h22});
    present();
    k = 0;
    while (!(busy === 1'b1 && uart_wr_en === 1'b0 && uart_tx_busy === 1'b1) && k < 20) begin step(); k++; end
    rises0 = wr_rises;
    req_valid[1]   = 1'b1;
    req_data[15:8] = 8'h99;
    @(negedge clk); #1;
    n_total++; if (req_ready !== 2'b00) $display("FAIL withdraw_ready: got %b expected 00", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    run("withdraw", 100);
    repeat (4) step();
    n_total++;
    if (wr_rises !== rises0) $display("FAIL withdraw_writes: got %0d expected %0d", wr_rises, rises0);
    else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs_rd >= obs_q.size()) $display("FAIL withdraw_sb: got none expected %h", e);
      else begin o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) $display("FAIL withdraw_sb: got %h expected %h", o, e); else n_pass++; end
    end
    n_total++;
    if (obs_rd != obs_q.size()) $display("FAIL withdraw_extra: got %0d extra expected 0", obs_q.size() - obs_rd);
    else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    obs_rd     = 0;
    rst_n      = 1'b0;
    force_busy = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    test_reset();
    test_single();
    test_contention();
    test_busy_idle();
    test_reset_drain();
    test_lock();
    test_withdraw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1);
  end

endmodule
